// File: rtl/frame_buffer_port_a_ctrl.sv
// Frame buffer Port A sequencer: shares the port between CPU single-pixel
// read/write (priority) and a raster rectangle-fill engine.
module frame_buffer_port_a_ctrl #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic              CPU_WDATA,
    output logic              CPU_ACK,
    output logic              CPU_RDATA,
    input  logic              FILL_START,
    input  logic [X_W-1:0]    FILL_X0,
    input  logic [X_W-1:0]    FILL_X1,
    input  logic [Y_W-1:0]    FILL_Y0,
    input  logic [Y_W-1:0]    FILL_Y1,
    input  logic              FILL_COLOUR,
    output logic              FILL_BUSY,
    output logic              FILL_DONE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic              FB_DATA_IN,
    output logic              FB_WE,
    input  logic              FB_DATA_OUT
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_WR,
        CPU_RD_ADDR,
        CPU_RD_WAIT,
        CPU_RD_ACK,
        FILL
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0]    xmin_q, xmin_d, xmax_q, xmax_d, cx_q, cx_d;
    logic [Y_W-1:0]    ymin_q, ymin_d, ymax_q, ymax_d, cy_q, cy_d;
    logic              colour_q, colour_d;
    logic              pend_q, pend_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ack_q, ack_d;
    logic              rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              din_q, din_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              accept;
    logic              pend_eff;
    logic              fill_go;
    logic [X_W-1:0]    in_xlo, in_xhi, eff_xmin, eff_xmax, eff_cx;
    logic [Y_W-1:0]    in_ylo, in_yhi, eff_ymin, eff_ymax, eff_cy;
    logic              eff_colour;

    assign accept = FILL_START && !busy_q && !pend_q;

    assign in_xlo = (FILL_X0 <= FILL_X1) ? FILL_X0 : FILL_X1;
    assign in_xhi = (FILL_X0 <= FILL_X1) ? FILL_X1 : FILL_X0;
    assign in_ylo = (FILL_Y0 <= FILL_Y1) ? FILL_Y0 : FILL_Y1;
    assign in_yhi = (FILL_Y0 <= FILL_Y1) ? FILL_Y1 : FILL_Y0;

    // A fill accepted this cycle can issue its first pixel on the next edge,
    // so the pixel engine works from these merged "effective" values.
    assign eff_xmin   = accept ? in_xlo      : xmin_q;
    assign eff_xmax   = accept ? in_xhi      : xmax_q;
    assign eff_ymin   = accept ? in_ylo      : ymin_q;
    assign eff_ymax   = accept ? in_yhi      : ymax_q;
    assign eff_cx     = accept ? in_xlo      : cx_q;
    assign eff_cy     = accept ? in_ylo      : cy_q;
    assign eff_colour = accept ? FILL_COLOUR : colour_q;
    assign pend_eff   = accept || pend_q;

    always_comb begin
        state_d  = state_q;
        xmin_d   = eff_xmin;
        xmax_d   = eff_xmax;
        ymin_d   = eff_ymin;
        ymax_d   = eff_ymax;
        cx_d     = eff_cx;
        cy_d     = eff_cy;
        colour_d = eff_colour;
        pend_d   = pend_eff;
        last_d   = 1'b0;
        done_d   = last_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        din_d    = din_q;
        addr_d   = addr_q;
        fill_go  = 1'b0;

        case (state_q)
            IDLE, FILL: begin
                if (CPU_REQ) begin
                    addr_d = CPU_ADDR;
                    if (CPU_WE) begin
                        state_d = CPU_WR;
                        we_d    = 1'b1;
                        din_d   = CPU_WDATA;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = CPU_RD_ADDR;
                    end
                end else begin
                    fill_go = 1'b1;
                end
            end
            CPU_WR, CPU_RD_ACK: fill_go = 1'b1;
            CPU_RD_ADDR:        state_d = CPU_RD_WAIT;
            CPU_RD_WAIT: begin
                rdata_d = FB_DATA_OUT;
                ack_d   = 1'b1;
                state_d = CPU_RD_ACK;
            end
            default:            state_d = IDLE;
        endcase

        if (fill_go) begin
            if (pend_eff) begin
                state_d = FILL;
                we_d    = 1'b1;
                addr_d  = ADDR_W'({eff_cy, eff_cx});
                din_d   = eff_colour;
                // Equality compares keep xmax=255 / ymax=127 from wrapping.
                if (eff_cx == eff_xmax) begin
                    cx_d = eff_xmin;
                    if (eff_cy == eff_ymax) begin
                        last_d = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        cy_d = eff_cy + 1'b1;
                    end
                end else begin
                    cx_d = eff_cx + 1'b1;
                end
            end else begin
                state_d = IDLE;
            end
        end

        busy_d = pend_d || last_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            colour_q <= 1'b0;
            pend_q   <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= 1'b0;
            we_q     <= 1'b0;
            din_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            colour_q <= colour_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            din_q    <= din_d;
            addr_q   <= addr_d;
        end
    end

    assign CPU_ACK    = ack_q;
    assign CPU_RDATA  = rdata_q;
    assign FILL_BUSY  = busy_q;
    assign FILL_DONE  = done_q;
    assign FB_ADDR    = addr_q;
    assign FB_DATA_IN = din_q;
    assign FB_WE      = we_q;

endmodule

// File: tb/tb_frame_buffer_port_a_ctrl.sv
// Directed bench for frame_buffer_port_a_ctrl with a registered-read
// 32768x1 frame buffer model attached to Port A.
module tb_frame_buffer_port_a_ctrl;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ADDR_W = 15;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CPU_REQ, CPU_WE, CPU_WDATA;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic              CPU_ACK, CPU_RDATA;
    logic              FILL_START, FILL_COLOUR;
    logic [X_W-1:0]    FILL_X0, FILL_X1;
    logic [Y_W-1:0]    FILL_Y0, FILL_Y1;
    logic              FILL_BUSY, FILL_DONE;
    logic [ADDR_W-1:0] FB_ADDR;
    logic              FB_DATA_IN, FB_WE;
    logic              FB_DATA_OUT = 1'b0;

    logic              mem [0:(1<<ADDR_W)-1];
    logic [20:0]       outs;

    int nvec = 0;
    int nerr = 0;

    frame_buffer_port_a_ctrl #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .FILL_START(FILL_START), .FILL_X0(FILL_X0), .FILL_X1(FILL_X1),
        .FILL_Y0(FILL_Y0), .FILL_Y1(FILL_Y1), .FILL_COLOUR(FILL_COLOUR),
        .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
        .FB_ADDR(FB_ADDR), .FB_DATA_IN(FB_DATA_IN), .FB_WE(FB_WE), .FB_DATA_OUT(FB_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (FB_WE) mem[FB_ADDR] <= FB_DATA_IN;
        FB_DATA_OUT <= mem[FB_ADDR];
    end

    assign outs = {CPU_ACK, CPU_RDATA, FILL_BUSY, FILL_DONE, FB_WE, FB_DATA_IN, FB_ADDR};

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        step;
        step;
        nvec++;
        if (outs !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got %h expected %h", outs, 21'h0);
        end
        RESET = 1'b0;
        step;
        nvec++;
        if (outs !== '0) begin
            nerr++;
            $display("FAIL post_reset_idle: got %h expected %h", outs, 21'h0);
        end
    endtask

    task automatic test_cpu_rw;
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h1234; CPU_WDATA = 1'b1;
        step;
        nvec++;
        if ({CPU_ACK, FB_WE, FB_DATA_IN, FB_ADDR} !== {3'b111, 15'h1234}) begin
            nerr++;
            $display("FAIL cpu_wr_cycle: got %h expected %h",
                     {CPU_ACK, FB_WE, FB_DATA_IN, FB_ADDR}, {3'b111, 15'h1234});
        end
        step;
        CPU_REQ = 1'b0;
        nvec++;
        if ({CPU_ACK, FB_WE} !== 2'b00) begin
            nerr++;
            $display("FAIL cpu_wr_single_pulse: got %b expected %b", {CPU_ACK, FB_WE}, 2'b00);
        end
        step;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h1234;
        step;
        nvec++;
        if ({CPU_ACK, FB_WE, FB_ADDR} !== {2'b00, 15'h1234}) begin
            nerr++;
            $display("FAIL cpu_rd_addr: got %h expected %h", {CPU_ACK, FB_WE, FB_ADDR}, {2'b00, 15'h1234});
        end
        step;
        nvec++;
        if ({CPU_ACK, FB_WE} !== 2'b00) begin
            nerr++;
            $display("FAIL cpu_rd_wait: got %b expected %b", {CPU_ACK, FB_WE}, 2'b00);
        end
        step;
        nvec++;
        if ({CPU_ACK, CPU_RDATA, FB_WE} !== 3'b110) begin
            nerr++;
            $display("FAIL cpu_rd_ack: got %b expected %b", {CPU_ACK, CPU_RDATA, FB_WE}, 3'b110);
        end
        step;
        CPU_REQ = 1'b0;
        nvec++;
        if ({CPU_ACK, CPU_RDATA} !== 2'b01) begin
            nerr++;
            $display("FAIL cpu_rd_hold: got %b expected %b", {CPU_ACK, CPU_RDATA}, 2'b01);
        end
        step;
    endtask

    task automatic test_fill_rect(input string nm, input logic [7:0] x0, input logic [7:0] x1,
                                  input logic [6:0] y0, input logic [6:0] y1);
        logic [14:0] exp_a [8];
        exp_a = '{15'h0102, 15'h0103, 15'h0104, 15'h0105,
                  15'h0202, 15'h0203, 15'h0204, 15'h0205};
        FILL_X0 = x0; FILL_X1 = x1; FILL_Y0 = y0; FILL_Y1 = y1;
        FILL_COLOUR = 1'b1; FILL_START = 1'b1;
        nvec++;
        if (FILL_BUSY !== 1'b0) begin
            nerr++;
            $display("FAIL %s_busy_before: got %b expected 0", nm, FILL_BUSY);
        end
        step;
        FILL_START = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if ({FB_WE, FB_DATA_IN, FILL_BUSY, FILL_DONE, FB_ADDR} !== {4'b1110, exp_a[i]}) begin
                nerr++;
                $display("FAIL %s_write%0d: got %h expected %h", nm, i,
                         {FB_WE, FB_DATA_IN, FILL_BUSY, FILL_DONE, FB_ADDR}, {4'b1110, exp_a[i]});
            end
            step;
        end
        nvec++;
        if ({FB_WE, FILL_BUSY, FILL_DONE} !== 3'b001) begin
            nerr++;
            $display("FAIL %s_done: got %b expected %b", nm, {FB_WE, FILL_BUSY, FILL_DONE}, 3'b001);
        end
        step;
        nvec++;
        if ({FB_WE, FILL_BUSY, FILL_DONE} !== 3'b000) begin
            nerr++;
            $display("FAIL %s_after_done: got %b expected %b", nm, {FB_WE, FILL_BUSY, FILL_DONE}, 3'b000);
        end
    endtask

    task automatic test_full_fill;
        int nwr = 0, ndone = 0, seqerr = 0, extra = 0;
        logic [14:0] expa = '0;
        logic [14:0] lasta = '0;
        FILL_X0 = 8'd0; FILL_X1 = 8'd255; FILL_Y0 = 7'd0; FILL_Y1 = 7'd127;
        FILL_COLOUR = 1'b0; FILL_START = 1'b1;
        step;
        FILL_START = 1'b0;
        for (int c = 0; c < 33000; c++) begin
            if (FB_WE) begin
                if (FB_ADDR !== expa || FB_DATA_IN !== 1'b0) seqerr++;
                expa  = expa + 1'b1;
                lasta = FB_ADDR;
                nwr++;
            end
            if (FILL_DONE) begin
                ndone++;
                break;
            end
            step;
        end
        for (int c = 0; c < 4; c++) begin
            step;
            if (FILL_DONE || FB_WE || FILL_BUSY) extra++;
        end
        nvec++;
        if (nwr != 32768) begin
            nerr++;
            $display("FAIL full_write_count: got %0d expected 32768", nwr);
        end
        nvec++;
        if (lasta !== 15'h7FFF) begin
            nerr++;
            $display("FAIL full_last_addr: got %h expected 7fff", lasta);
        end
        nvec++;
        if (seqerr != 0) begin
            nerr++;
            $display("FAIL full_sequence: got %0d out-of-order writes expected 0", seqerr);
        end
        nvec++;
        if (ndone != 1 || extra != 0) begin
            nerr++;
            $display("FAIL full_done_once: got done=%0d extra=%0d expected 1/0", ndone, extra);
        end
    endtask

    task automatic test_preempt;
        logic [3:0]  exp_f [12];
        logic [14:0] exp_a [12];
        exp_f = '{4'b1001, 4'b0001, 4'b0001, 4'b0101, 4'b1001, 4'b1001,
                  4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0010};
        exp_a = '{15'h0102, 15'h0102, 15'h0, 15'h0, 15'h0103, 15'h0104,
                  15'h0105, 15'h0202, 15'h0203, 15'h0204, 15'h0205, 15'h0};
        FILL_X0 = 8'd2; FILL_X1 = 8'd5; FILL_Y0 = 7'd1; FILL_Y1 = 7'd2;
        FILL_COLOUR = 1'b1; FILL_START = 1'b1;
        step;
        FILL_START = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nvec++;
            if ({FB_WE, CPU_ACK, FILL_DONE, FILL_BUSY} !== exp_f[i] ||
                ((exp_f[i][3] || i == 1) && FB_ADDR !== exp_a[i])) begin
                nerr++;
                $display("FAIL preempt_cycle%0d: got we/ack/done/busy=%b addr=%h expected %b addr=%h",
                         i, {FB_WE, CPU_ACK, FILL_DONE, FILL_BUSY}, FB_ADDR, exp_f[i], exp_a[i]);
            end
            if (i == 3) begin
                nvec++;
                if (CPU_RDATA !== 1'b1) begin
                    nerr++;
                    $display("FAIL preempt_rdata: got %b expected 1", CPU_RDATA);
                end
            end
            if (i == 0) begin
                CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h0102;
            end
            if (i == 4) CPU_REQ = 1'b0;
            step;
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0]  exp_f [4];
        logic [14:0] exp_a [4];
        exp_f = '{4'b1101, 4'b1001, 4'b1001, 4'b0010};
        exp_a = '{15'h0010, 15'h0300, 15'h0301, 15'h0};
        FILL_X0 = 8'd1; FILL_X1 = 8'd0; FILL_Y0 = 7'd3; FILL_Y1 = 7'd3;
        FILL_COLOUR = 1'b1; FILL_START = 1'b1;
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h0010; CPU_WDATA = 1'b1;
        step;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ({FB_WE, CPU_ACK, FILL_DONE, FILL_BUSY} !== exp_f[i] ||
                (exp_f[i][3] && FB_ADDR !== exp_a[i])) begin
                nerr++;
                $display("FAIL simul_cycle%0d: got we/ack/done/busy=%b addr=%h expected %b addr=%h",
                         i, {FB_WE, CPU_ACK, FILL_DONE, FILL_BUSY}, FB_ADDR, exp_f[i], exp_a[i]);
            end
            if (i == 0) FILL_START = 1'b0;
            if (i == 1) CPU_REQ = 1'b0;
            step;
        end
    endtask

    task automatic test_reset_midfill;
        FILL_X0 = 8'd0; FILL_X1 = 8'd9; FILL_Y0 = 7'd0; FILL_Y1 = 7'd0;
        FILL_COLOUR = 1'b1; FILL_START = 1'b1;
        step;
        FILL_START = 1'b0;
        step;
        step;
        #3;
        RESET = 1'b1;
        #1;
        nvec++;
        if (outs !== '0) begin
            nerr++;
            $display("FAIL midfill_async_reset: got %h expected %h", outs, 21'h0);
        end
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        step;
        nvec++;
        if (outs !== '0) begin
            nerr++;
            $display("FAIL midfill_no_done: got %h expected %h", outs, 21'h0);
        end
        FILL_X0 = 8'd7; FILL_X1 = 8'd7; FILL_Y0 = 7'd5; FILL_Y1 = 7'd5;
        FILL_START = 1'b1;
        step;
        FILL_START = 1'b0;
        nvec++;
        if ({FB_WE, FILL_BUSY, FILL_DONE, FB_DATA_IN, FB_ADDR} !== {4'b1101, 15'h0507}) begin
            nerr++;
            $display("FAIL restart_single_write: got %h expected %h",
                     {FB_WE, FILL_BUSY, FILL_DONE, FB_DATA_IN, FB_ADDR}, {4'b1101, 15'h0507});
        end
        step;
        nvec++;
        if ({FB_WE, FILL_BUSY, FILL_DONE} !== 3'b001) begin
            nerr++;
            $display("FAIL restart_single_done: got %b expected %b", {FB_WE, FILL_BUSY, FILL_DONE}, 3'b001);
        end
        step;
    endtask

    initial begin
        RESET = 1'b1;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = 1'b0;
        FILL_START = 1'b0; FILL_COLOUR = 1'b0;
        FILL_X0 = '0; FILL_X1 = '0; FILL_Y0 = '0; FILL_Y1 = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 1'b0;

        test_reset;
        test_cpu_rw;
        test_fill_rect("fill_fwd", 8'd2, 8'd5, 7'd1, 7'd2);
        step;
        test_fill_rect("fill_rev", 8'd5, 8'd2, 7'd2, 7'd1);
        step;
        test_full_fill;
        test_preempt;
        step;
        test_simultaneous;
        test_reset_midfill;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
